seq_ripple_adder: RTL
=====================

// Module: seq_ripple_adder
// PURPOSE
//  Multi-cycle, parametrised successor to the 64-bit combinational ripple carry adder.
//  Adds in1 + in2 + c_in one SLICE-bit ripple segment per clock, storing the carry between cycles.
//  Input and output use valid/ready handshakes, so the block slots into the datapath as a
//  small-area adder with predictable latency.
// PARAMETERS
//  WIDTH  64  operand/sum width in bits; must be >= 1
//  SLICE  16  bits added per clock; 1 <= SLICE <= WIDTH, WIDTH % SLICE == 0 (elaboration error otherwise)
//  NSLICE = WIDTH/SLICE (localparam): number of compute cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands presented
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  in1        in   WIDTH  operand A, unsigned / two's complement
//  in2        in   WIDTH  operand B
//  c_in       in   1      carry into bit 0
//  out_valid  out  1      result held and valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  in1 + in2 + c_in, modulo 2^WIDTH
//  c_out      out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (present only when SEQ_ADD_OVF_EN is defined)
// BEHAVIOUR
//  - FSM states: IDLE, CALC, DONE. Reset -> IDLE. On reset: sum=0, c_out=0, ovf=0, out_valid=0,
//    slice counter=0, carry reg=0. in_ready=1 after reset (decoded from IDLE).
//  - IDLE: in_ready=1. On the edge where in_valid&&in_ready, latch in1, in2 and c_in (carry reg=c_in).
//    Clear the counter and go to CALC. Operand changes after capture have no effect.
//  - CALC: in_ready=0, out_valid=0. At each edge, for counter i:
//      {carry, sum[i*SLICE +: SLICE]} = a[i*SLICE +: SLICE] + b[i*SLICE +: SLICE] + carry; i++.
//    After the edge that computes slice NSLICE-1: c_out=carry and go to DONE.
//  - Latency: out_valid rises exactly NSLICE clocks after the accepting edge (4 for 64/16).
//    With SLICE==WIDTH, latency is 1.
//  - DONE: out_valid=1. sum, c_out and ovf stay stable until out_valid&&out_ready.
//    At that edge: out_valid=0, go to IDLE, in_ready=1 the following cycle.
//    No input is accepted in the same cycle as output transfer.
//    Minimum issue interval: NSLICE+2 clocks.
//  - out_ready held low: stay in DONE indefinitely, outputs frozen.
//    out_ready is ignored outside DONE.
//  - in_valid outside IDLE is ignored; the operands are not queued.
//  - sum changes slice-by-slice during CALC; it is meaningful only while out_valid=1.
//  - rst asserted at any time (including mid-CALC or in DONE): state, outputs and counter return to
//    reset values immediately. The partial result is discarded; no out_valid is produced for it.
//  - Wrap-around: all-ones + 0 + c_in=1 -> sum=0, c_out=1. No other status is generated.
// CONFIGURATION
//  - SEQ_ADD_OVF_EN defined: port ovf exists. In the edge computing the final slice,
//    ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]). It is held with sum in DONE and reset to 0.
//  - SEQ_ADD_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.
// TESTING (WIDTH=64, SLICE=16 unless noted)
//  1. in1=12345678912345, in2=98765432198765, c_in=0, out_ready=1
//     -> sum=111111111111110, c_out=0, out_valid 4 clks after accept.
//  2. Same operands, c_in=1 -> sum=111111111111111, c_out=0.
//     Then in1=-12345678912345, in2=98765432198765, c_in=0 -> sum=86419753286420, c_out=1.
//  3. in1=64'hFFFF_FFFF_FFFF_FFFF, in2=0, c_in=1 -> sum=0, c_out=1
//     (carry ripples across all 4 slices).
//     With SEQ_ADD_OVF_EN: in1=64'h7FFF_FFFF_FFFF_FFFF, in2=1 -> sum=64'h8000_0000_0000_0000, c_out=0, ovf=1.
//  4. Backpressure: hold out_ready=0 for 10 clks after out_valid.
//     -> out_valid, sum, c_out stay stable and in_ready=0 throughout.
//     Raise out_ready -> one transfer, in_ready=1 next clk.
//  5. Assert rst for 1 clk after 2 CALC cycles -> all outputs 0, in_ready=1, no out_valid for that op.
//     The next op (5+7, c_in=0) -> sum=12.
//  6. Re-elaborate with SLICE=64 and SLICE=1, run scenario 1 -> same sum with latencies 1 and 64.
//     Randomised 1000 ops vs the behavioural + reference model.

Source files
------------

// File: rtl/seq_ripple_adder.sv
// seq_ripple_adder: multi-cycle adder that adds SLICE bits per clock and keeps the carry between cycles.
// Optional macro SEQ_ADD_OVF_EN adds the signed-overflow output ovf.
module seq_ripple_adder #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("seq_ripple_adder: illegal WIDTH/SLICE combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             c_out_reg;
    logic [CW-1:0]    cnt;
    int               base;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_sum;
    logic             last;
`ifdef SEQ_ADD_OVF_EN
    logic             ovf_reg;
`endif

    assign base      = int'(cnt) * SLICE;
    assign a_slice   = a_reg[base +: SLICE];
    assign b_slice   = b_reg[base +: SLICE];
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
    assign last      = (cnt == CW'(NSLICE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operands are captured once on accept; the sum register fills one slice per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            c_out_reg <= 1'b0;
            cnt       <= '0;
`ifdef SEQ_ADD_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in1;
                        b_reg <= in2;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    sum_reg[base +: SLICE] <= slice_sum[SLICE-1:0];
                    carry                  <= slice_sum[SLICE];
                    if (last) begin
                        cnt       <= '0;
                        c_out_reg <= slice_sum[SLICE];
`ifdef SEQ_ADD_OVF_EN
                        ovf_reg   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
`ifdef SEQ_ADD_OVF_EN
    assign ovf       = ovf_reg;
`endif

endmodule
